// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap controller: register map, ap_ctrl bit positions, FSM states.
package fir_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_TAP_BASE = 32'h20;

  localparam int unsigned AP_START  = 0;
  localparam int unsigned AP_DONE   = 1;
  localparam int unsigned AP_IDLE   = 2;
  localparam int unsigned TLAST_ERR = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_axil_regs.sv
// AXI-lite slave for the FIR controller: handshakes, data_length register, ap_ctrl read-back
// and tap request decode (tap accesses are only forwarded while the engine is idle).
module fir_axil_regs
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pTAP_NUM    = 11,
  localparam int unsigned TAP_AW     = $clog2(pTAP_NUM)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ap_done,
  input  logic                   ap_idle,
  input  logic                   tlast_err,
  input  logic [pDATA_WIDTH-1:0] tap_do,
  output logic [pDATA_WIDTH-1:0] data_length,
  output logic                   start_c,
  output logic                   ctrl_rd_c,
  output logic                   tap_wr_c,
  output logic                   tap_rd_c,
  output logic [TAP_AW-1:0]      tap_idx_c,
  output logic [pDATA_WIDTH-1:0] tap_wdata_c
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_LO = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_HI = pADDR_WIDTH'(ADDR_TAP_BASE + pTAP_NUM);

  logic                   wr_go;
  logic                   rd_go;
  logic                   w_tap;
  logic                   r_tap;
  logic                   rd_tap_q;
  logic [pDATA_WIDTH-1:0] rd_val;
  logic [pDATA_WIDTH-1:0] rdata_q;

  // A pending write always wins; the read is taken no earlier than the write's ack cycle.
  assign wr_go = awvalid && wvalid && !awready;
  assign rd_go = arvalid && !arready && !rvalid && !wr_go;

  assign w_tap = (awaddr >= A_TAP_LO) && (awaddr < A_TAP_HI);
  assign r_tap = (araddr >= A_TAP_LO) && (araddr < A_TAP_HI);

  assign start_c     = awready && (awaddr == A_CTRL) && ap_idle
                       && |(wdata & (pDATA_WIDTH'(1) << AP_START));
  assign ctrl_rd_c   = arready && (araddr == A_CTRL);
  assign tap_wr_c    = awready && w_tap && ap_idle;
  assign tap_rd_c    = arready && r_tap && ap_idle;
  assign tap_idx_c   = arready ? TAP_AW'(araddr - A_TAP_LO) : TAP_AW'(awaddr - A_TAP_LO);
  assign tap_wdata_c = wdata;

  // Read value for everything except an idle tap read, which comes straight from the RAM.
  always_comb begin
    rd_val = '0;
    if (araddr == A_CTRL) begin
      rd_val = (pDATA_WIDTH'(ap_done)   << AP_DONE)
             | (pDATA_WIDTH'(ap_idle)   << AP_IDLE)
             | (pDATA_WIDTH'(tlast_err) << TLAST_ERR);
    end else if (araddr == A_LEN) begin
      rd_val = data_length;
    end else if (r_tap && !ap_idle) begin
      rd_val = '1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rd_tap_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      awready  <= wr_go;
      wready   <= wr_go;
      arready  <= rd_go;
      rd_tap_q <= tap_rd_c;
      if (arready) begin
        rvalid <= 1'b1;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
      if (arready) begin
        rdata_q <= rd_val;
      end else if (rd_tap_q) begin
        rdata_q <= tap_do;
      end
    end
  end

  // RAM data is only valid in the first rvalid cycle; it is held in rdata_q afterwards.
  assign rdata = rd_tap_q ? tap_do : rdata_q;

  // data_length survives reset by design.
  always_ff @(posedge axis_clk) begin
    if (awready && (awaddr == A_LEN) && ap_idle) begin
      data_length <= wdata;
    end
  end

endmodule

// File: rtl/fir_tap_ctrl.sv
// FIR accelerator control: per-sample sequencing (LOAD/MAC/OUT) and tap RAM arbitration.
// Optional macro FIR_TLAST_CHECK_EN adds ss_tlast checking and the sticky tlast_err bit.
module fir_tap_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pTAP_NUM    = 11,
  localparam int unsigned TAP_AW     = $clog2(pTAP_NUM)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic                   tap_en,
  output logic                   tap_we,
  output logic [TAP_AW-1:0]      tap_addr,
  output logic [pDATA_WIDTH-1:0] tap_di,
  input  logic [pDATA_WIDTH-1:0] tap_do,
  output logic                   smp_load,
  output logic                   mac_en,
  output logic [TAP_AW-1:0]      mac_idx
);

  localparam int unsigned       MAC_CW   = $clog2(pTAP_NUM + 1);
  localparam logic [MAC_CW-1:0] MAC_LAST = MAC_CW'(pTAP_NUM);

  fir_state_e             state;
  fir_state_e             state_nxt;
  logic [pDATA_WIDTH-1:0] data_length;
  logic [pDATA_WIDTH-1:0] count;
  logic [MAC_CW-1:0]      mac_cnt;
  logic                   ap_done;
  logic                   ap_idle;
  logic                   tlast_err;
  logic                   early_last;
  logic                   cnt_last;
  logic                   is_last;
  logic                   eng_rd;
  logic                   start_c;
  logic                   ctrl_rd_c;
  logic                   tap_wr_c;
  logic                   tap_rd_c;
  logic [TAP_AW-1:0]      tap_idx_c;
  logic [pDATA_WIDTH-1:0] tap_wdata_c;

  fir_axil_regs #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .pTAP_NUM    (pTAP_NUM)
  ) u_regs (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .tlast_err   (tlast_err),
    .tap_do      (tap_do),
    .data_length (data_length),
    .start_c     (start_c),
    .ctrl_rd_c   (ctrl_rd_c),
    .tap_wr_c    (tap_wr_c),
    .tap_rd_c    (tap_rd_c),
    .tap_idx_c   (tap_idx_c),
    .tap_wdata_c (tap_wdata_c)
  );

  assign cnt_last = (count == data_length - pDATA_WIDTH'(1));
  assign is_last  = cnt_last || early_last;
  assign eng_rd   = (state == MAC) && (mac_cnt < MAC_LAST);

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_c && (data_length != '0)) state_nxt = LOAD;
      LOAD:    if (ss_tvalid) state_nxt = MAC;
      MAC:     if (mac_cnt == MAC_LAST) state_nxt = OUT;
      OUT:     if (sm_tready) state_nxt = is_last ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream flow control plus tap RAM mux: the engine owns the RAM during its walk.
  always_comb begin
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    smp_load  = 1'b0;
    tap_en    = 1'b0;
    tap_we    = 1'b0;
    tap_addr  = '0;
    tap_di    = '0;
    case (state)
      LOAD: begin
        ss_tready = 1'b1;
        smp_load  = ss_tvalid;
      end
      OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = is_last;
      end
      default: ;
    endcase
    if (eng_rd) begin
      tap_en   = 1'b1;
      tap_addr = TAP_AW'(mac_cnt);
    end else if (tap_wr_c || tap_rd_c) begin
      tap_en   = 1'b1;
      tap_we   = tap_wr_c;
      tap_addr = tap_idx_c;
      tap_di   = tap_wdata_c;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      count   <= '0;
      mac_cnt <= '0;
      mac_en  <= 1'b0;
      mac_idx <= '0;
      ap_done <= 1'b0;
      ap_idle <= 1'b1;
    end else begin
      mac_en  <= eng_rd;
      mac_idx <= eng_rd ? TAP_AW'(mac_cnt) : '0;
      mac_cnt <= ((state == MAC) && (state_nxt == MAC)) ? mac_cnt + MAC_CW'(1) : '0;
      // A status read clears done; a completion in the same cycle takes priority below.
      if (ctrl_rd_c) begin
        ap_done <= 1'b0;
      end
      if (state == IDLE) begin
        if (start_c) begin
          count   <= '0;
          ap_done <= 1'b0;
          ap_idle <= 1'b0;
        end else if (!ap_idle) begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
        end
      end
      if ((state == OUT) && sm_tready) begin
        count <= count + pDATA_WIDTH'(1);
        if (is_last) begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
        end
      end
    end
  end

`ifdef FIR_TLAST_CHECK_EN
  // tlast disagreement is sticky; an early tlast also ends the run after its output.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      tlast_err  <= 1'b0;
      early_last <= 1'b0;
    end else begin
      if (ctrl_rd_c) begin
        tlast_err <= 1'b0;
      end
      if (state == IDLE) begin
        early_last <= 1'b0;
      end
      if (smp_load) begin
        if (ss_tlast && !cnt_last) begin
          tlast_err  <= 1'b1;
          early_last <= 1'b1;
        end else if (!ss_tlast && cnt_last) begin
          tlast_err <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = ss_tlast;
  assign tlast_err    = 1'b0;
  assign early_last   = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Directed self-checking bench for fir_tap_ctrl with a behavioural tap RAM and stream monitors.
module tb_fir_tap_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, arready, rvalid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, sm_tready = 1'b0;
  logic          ss_tready, sm_tvalid, sm_tlast;
  logic          tap_en, tap_we, smp_load, mac_en;
  logic [3:0]    tap_addr, mac_idx;
  logic [DW-1:0] tap_di;
  logic [DW-1:0] tap_do = '0;
  logic [DW-1:0] ram [0:NT-1];

  int n_assert = 0;
  int n_fail   = 0;

  int beats = 0, tl_beats = 0, tl_pos = 0, loads = 0;
  int mac_cyc = 0, idx_err = 0, run_err = 0, run_len = 0, tap_sum = 0;
  logic [3:0] exp_idx = '0;

  int taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  fir_tap_ctrl dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .ss_tvalid (ss_tvalid),
    .ss_tready (ss_tready),
    .ss_tlast  (ss_tlast),
    .sm_tvalid (sm_tvalid),
    .sm_tready (sm_tready),
    .sm_tlast  (sm_tlast),
    .tap_en    (tap_en),
    .tap_we    (tap_we),
    .tap_addr  (tap_addr),
    .tap_di    (tap_di),
    .tap_do    (tap_do),
    .smp_load  (smp_load),
    .mac_en    (mac_en),
    .mac_idx   (mac_idx)
  );

  always #5 axis_clk = ~axis_clk;

  // Single-port tap RAM, read-first, one-cycle read latency.
  always @(posedge axis_clk) begin
    if (tap_en && (tap_addr < 4'(NT))) begin
      if (tap_we) ram[tap_addr] <= tap_di;
      tap_do <= ram[tap_addr];
    end
  end

  // Stream and MAC observers, sampled mid-cycle.
  always @(negedge axis_clk) begin
    if (!axis_rst) begin
      if (sm_tvalid && sm_tready) begin
        beats++;
        if (sm_tlast) begin
          tl_beats++;
          tl_pos = beats;
        end
      end
      if (smp_load) loads++;
      if (mac_en) begin
        mac_cyc++;
        if (mac_idx != exp_idx) idx_err++;
        exp_idx = exp_idx + 4'd1;
        run_len++;
        tap_sum += int'($signed(tap_do));
      end else begin
        if (run_len != 0 && run_len != int'(NT)) run_err++;
        run_len = 0;
        exp_idx = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge axis_clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 20) begin @(negedge axis_clk); n++; end
    check("aw_ack", 32'(n < 20), 32'd1);
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [AW-1:0] a, input int hold, output logic [DW-1:0] d);
    int n = 0;
    @(negedge axis_clk);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge axis_clk); n++; end
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    while (!rvalid && n < 40) begin @(negedge axis_clk); n++; end
    check("r_valid", 32'(rvalid), 32'd1);
    repeat (hold) @(negedge axis_clk);
    d = rdata;
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats < target && n < 1000) begin @(negedge axis_clk); n++; end
    repeat (3) @(negedge axis_clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int b0, l0, t0, m0, i0, r0, s0;
    for (int i = 0; i < int'(NT); i++) ram[i] = '0;

    // Reset state
    repeat (3) @(negedge axis_clk);
    axis_rst = 1'b0;
    @(negedge axis_clk);
    check("rst_outs", 32'({ss_tready, sm_tvalid, mac_en, smp_load, awready, arready, rvalid}), 32'd0);
    axil_read(12'h000, 0, rd); check("rst_ctrl", rd, 32'h4);

    // Test 1: tap programming and read-back
    for (int i = 0; i < int'(NT); i++) axil_write(AW'(32'h20 + i), DW'(taps[i]));
    axil_write(12'h010, 32'd600);
    for (int i = 0; i < int'(NT); i++) begin
      axil_read(AW'(32'h20 + i), (i == 5) ? 3 : 0, rd);
      check($sformatf("tap%0d", i), rd, DW'(taps[i]));
    end
    axil_read(12'h010, 0, rd); check("len600", rd, 32'd600);
    axil_read(12'h000, 0, rd); check("ctrl_idle", rd, 32'h4);
    axil_read(12'h100, 0, rd); check("unmapped", rd, 32'h0);

    // Simultaneous write and read: the write lands first
    @(negedge axis_clk);
    awaddr = 12'h010; wdata = 32'd7; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h010; arvalid = 1'b1;
    @(negedge axis_clk);
    check("wr_first", 32'({awready, arready}), 32'b10);
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge axis_clk);
    check("rd_next", 32'(arready), 32'd1);
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    @(negedge axis_clk);
    check("rd_after_wr", rdata, 32'd7);
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;

    // Test 2: three-sample run
    ss_tvalid = 1'b1; sm_tready = 1'b1;
    axil_write(12'h010, 32'd3);
    b0 = beats; l0 = loads; t0 = tl_beats; m0 = mac_cyc; i0 = idx_err; r0 = run_err; s0 = tap_sum;
    axil_write(12'h000, 32'h1);
    wait_beats(b0 + 3);
    repeat (20) @(negedge axis_clk);
    check("t2_beats", 32'(beats - b0), 32'd3);
    check("t2_loads", 32'(loads - l0), 32'd3);
    check("t2_tlast_n", 32'(tl_beats - t0), 32'd1);
    check("t2_tlast_pos", 32'(tl_pos - b0), 32'd3);
    check("t2_mac_cyc", 32'(mac_cyc - m0), 32'd33);
    check("t2_idx_err", 32'(idx_err - i0), 32'd0);
    check("t2_run_err", 32'(run_err - r0), 32'd0);
    check("t2_tap_sum", 32'(tap_sum - s0), 32'd549);
    axil_read(12'h000, 0, rd); check("t2_done", rd, 32'h6);
    axil_read(12'h000, 0, rd); check("t2_done_clr", rd, 32'h4);

    // Zero-length start finishes immediately
    axil_write(12'h010, 32'd0);
    b0 = beats;
    axil_write(12'h000, 32'h1);
    repeat (5) @(negedge axis_clk);
    check("z_beats", 32'(beats - b0), 32'd0);
    axil_read(12'h000, 0, rd); check("z_done", rd, 32'h6);
    axil_read(12'h000, 0, rd); check("z_clr", rd, 32'h4);

    // Test 3: AXI access during a run
    axil_write(12'h010, 32'd5);
    b0 = beats;
    axil_write(12'h000, 32'h1);
    axil_read(12'h000, 0, rd); check("t3_busy", rd, 32'h0);
    axil_write(12'h020, 32'h55);
    axil_write(12'h010, 32'd9);
    axil_read(12'h023, 0, rd); check("t3_tap_busy", rd, 32'hFFFF_FFFF);
    wait_beats(b0 + 5);
    check("t3_beats", 32'(beats - b0), 32'd5);
    axil_read(12'h020, 0, rd); check("t3_tap_kept", rd, 32'h0);
    axil_read(12'h010, 0, rd); check("t3_len_kept", rd, 32'd5);
    axil_read(12'h000, 0, rd); check("t3_done", rd, 32'h6);

    // Test 4: output back-pressure
    axil_write(12'h010, 32'd2);
    @(posedge axis_clk); #1;
    sm_tready = 1'b0;
    b0 = beats;
    axil_write(12'h000, 32'h1);
    for (int n = 0; n < 100 && !sm_tvalid; n++) @(negedge axis_clk);
    i0 = 0;
    for (int k = 0; k < 5; k++) begin
      if (sm_tvalid && !ss_tready) i0++;
      @(negedge axis_clk);
    end
    check("t4_hold", 32'(i0), 32'd5);
    check("t4_no_beat", 32'(beats - b0), 32'd0);
    @(posedge axis_clk); #1;
    sm_tready = 1'b1;
    wait_beats(b0 + 2);
    repeat (20) @(negedge axis_clk);
    check("t4_beats", 32'(beats - b0), 32'd2);
    axil_read(12'h000, 0, rd); check("t4_done", rd, 32'h6);

    // Test 5: reset in the middle of sample 2
    axil_write(12'h010, 32'd3);
    l0 = loads;
    axil_write(12'h000, 32'h1);
    for (int n = 0; n < 300 && !(loads >= l0 + 2 && mac_en); n++) @(negedge axis_clk);
    check("t5_in_mac", 32'(mac_en), 32'd1);
    @(posedge axis_clk); #1;
    axis_rst = 1'b1;
    #1;
    check("t5_rst_outs", 32'({ss_tready, sm_tvalid, sm_tlast, smp_load, mac_en, tap_en, tap_we,
                              awready, wready, arready, rvalid}), 32'd0);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    axil_read(12'h000, 0, rd); check("t5_ctrl", rd, 32'h4);
    axil_read(12'h010, 0, rd); check("t5_len_kept", rd, 32'd3);
    b0 = beats;
    axil_write(12'h000, 32'h1);
    wait_beats(b0 + 3);
    repeat (20) @(negedge axis_clk);
    check("t5_rerun", 32'(beats - b0), 32'd3);
    axil_read(12'h000, 0, rd); check("t5_done", rd, 32'h6);

`ifdef FIR_TLAST_CHECK_EN
    // Test 6: early tlast terminates the run and flags tlast_err
    axil_write(12'h010, 32'd4);
    b0 = beats; l0 = loads; t0 = tl_beats;
    axil_write(12'h000, 32'h1);
    for (int n = 0; n < 200 && loads < l0 + 1; n++) @(negedge axis_clk);
    @(posedge axis_clk); #1;
    ss_tlast = 1'b1;
    for (int n = 0; n < 200 && loads < l0 + 2; n++) @(negedge axis_clk);
    @(posedge axis_clk); #1;
    ss_tlast = 1'b0;
    wait_beats(b0 + 2);
    repeat (40) @(negedge axis_clk);
    check("t6_beats", 32'(beats - b0), 32'd2);
    check("t6_tlast_n", 32'(tl_beats - t0), 32'd1);
    check("t6_tlast_pos", 32'(tl_pos - b0), 32'd2);
    axil_read(12'h000, 0, rd); check("t6_ctrl", rd, 32'hE);
    axil_read(12'h000, 0, rd); check("t6_clr", rd, 32'h4);
`else
    // Without the check, ss_tlast is ignored entirely
    axil_write(12'h010, 32'd2);
    b0 = beats; l0 = loads; t0 = tl_beats;
    @(posedge axis_clk); #1;
    ss_tlast = 1'b1;
    axil_write(12'h000, 32'h1);
    for (int n = 0; n < 200 && loads < l0 + 1; n++) @(negedge axis_clk);
    @(posedge axis_clk); #1;
    ss_tlast = 1'b0;
    wait_beats(b0 + 2);
    repeat (20) @(negedge axis_clk);
    check("nt_beats", 32'(beats - b0), 32'd2);
    check("nt_tlast_pos", 32'(tl_pos - b0), 32'd2);
    check("nt_tlast_n", 32'(tl_beats - t0), 32'd1);
    axil_read(12'h000, 0, rd); check("nt_ctrl", rd, 32'h6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
